// File: rtl/harris_pkg.sv
// Shared widths, helpers and FSM state encoding for the Harris corner-response engine.
package harris_pkg;

    localparam int RW_DEFAULT = 48;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        MUL   = 2'd1,
        SUB   = 2'd2,
        OUT   = 2'd3
    } state_e;

    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Width of the signed structure-tensor sums for one window.
    function automatic int sw_width(input int gw, input int win);
        return 2 * gw + clog2(win * win) + 1;
    endfunction

endpackage

// File: rtl/harris_response_pipe_if.sv
// Gradient-in / response-out handshake bundle for harris_response_pipe.
interface harris_response_pipe_if
    import harris_pkg::*;
#(
    parameter int GW = 16,
    parameter int RW = RW_DEFAULT
);
    logic                 s_valid;
    logic                 s_ready;
    logic signed [GW-1:0] s_gx;
    logic signed [GW-1:0] s_gy;
    logic                 s_last;
    logic signed [RW-1:0] thresh;
    logic                 m_valid;
    logic                 m_ready;
    logic signed [RW-1:0] m_r;
    logic                 m_corner;
    logic                 m_err;

    modport slave (
        input  s_valid, s_gx, s_gy, s_last, thresh, m_ready,
        output s_ready, m_valid, m_r, m_corner, m_err
    );

    modport master (
        output s_valid, s_gx, s_gy, s_last, thresh, m_ready,
        input  s_ready, m_valid, m_r, m_corner, m_err
    );
endinterface

// File: rtl/harris_tensor_acc.sv
// Structure-tensor accumulator: sums gx^2, gy^2, gx*gy over one window and
// tracks the sample count and any s_last framing disagreement.
module harris_tensor_acc
    import harris_pkg::*;
#(
    parameter  int GW  = 16,
    parameter  int WIN = 4,
    localparam int SW  = sw_width(GW, WIN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 en,
    input  logic signed [GW-1:0] gx,
    input  logic signed [GW-1:0] gy,
    input  logic                 last,
    output logic [2:0][SW-1:0]   sums,
    output logic                 done,
    output logic                 err
);
    localparam int N  = WIN * WIN;
    localparam int CW = (clog2(N) > 0) ? clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    logic signed [SW-1:0] r_sxx, r_syy, r_sxy;
    logic [CW-1:0]        r_cnt;
    logic                 r_err;
    logic signed [SW-1:0] w_gx, w_gy;
    logic                 w_at_end;

    assign w_gx     = SW'(gx);
    assign w_gy     = SW'(gy);
    assign w_at_end = (r_cnt == LAST_CNT);
    assign done     = en && w_at_end;
    assign err      = r_err;
    assign sums[0]  = r_sxx;
    assign sums[1]  = r_syy;
    assign sums[2]  = r_sxy;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sxx <= '0;
            r_syy <= '0;
            r_sxy <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (clear) begin
            r_sxx <= '0;
            r_syy <= '0;
            r_sxy <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (en) begin
            r_sxx <= r_sxx + w_gx * w_gx;
            r_syy <= r_syy + w_gy * w_gy;
            r_sxy <= r_sxy + w_gx * w_gy;
            r_cnt <= w_at_end ? '0 : r_cnt + CW'(1);
            r_err <= r_err | (last != w_at_end);
        end
    end
endmodule

// File: rtl/harris_response_pipe.sv
// Harris corner-response engine: accumulate a WINxWIN gradient window, then
// R = det - ((K_NUM*trace^2) >>> K_SHIFT), saturated, behind a valid/ready output.
module harris_response_pipe
    import harris_pkg::*;
#(
    parameter int          GW      = 16,
    parameter int          WIN     = 4,
    parameter int unsigned K_NUM   = 5,
    parameter int          K_SHIFT = 7,
    parameter int          RW      = RW_DEFAULT
) (
    input logic                   clk,
    input logic                   rst_n,
    harris_response_pipe_if.slave bus
);
    localparam int SW = sw_width(GW, WIN);
    localparam int DW = 2 * SW + 1;
    localparam int KW = 2 * SW + 2 + clog2(K_NUM + 1);
    localparam int FW = KW + 1;
    localparam logic signed [KW-1:0] KNUM_W = KW'(K_NUM);

    state_e               r_state;
    logic                 r_live;
    logic signed [DW-1:0] r_sxx_syy, r_sxy2;
    logic signed [KW-1:0] r_tr2;
    logic signed [RW-1:0] r_m_r;
    logic                 r_m_corner, r_m_err;

    logic                 w_accept, w_release, w_done, w_err;
    logic [2:0][SW-1:0]   w_sums;
    logic signed [SW-1:0] w_sxx, w_syy, w_sxy;
    logic signed [DW-1:0] w_sxx_d, w_syy_d, w_sxy_d, w_det;
    logic signed [KW-1:0] w_trace, w_ktt;
    logic signed [FW-1:0] w_r;
    logic [FW-RW:0]       w_hi;
    logic signed [RW-1:0] w_r_sat;

    // r_live keeps s_ready low until the first edge after reset release.
    assign bus.s_ready  = r_live && (r_state == ACCUM);
    assign bus.m_valid  = (r_state == OUT);
    assign bus.m_r      = r_m_r;
    assign bus.m_corner = r_m_corner;
    assign bus.m_err    = r_m_err;

    assign w_accept  = bus.s_valid && bus.s_ready;
    assign w_release = (r_state == OUT) && bus.m_ready;

    harris_tensor_acc #(.GW(GW), .WIN(WIN)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_release),
        .en    (w_accept),
        .gx    (bus.s_gx),
        .gy    (bus.s_gy),
        .last  (bus.s_last),
        .sums  (w_sums),
        .done  (w_done),
        .err   (w_err)
    );

    assign w_sxx   = w_sums[0];
    assign w_syy   = w_sums[1];
    assign w_sxy   = w_sums[2];
    assign w_sxx_d = DW'(w_sxx);
    assign w_syy_d = DW'(w_syy);
    assign w_sxy_d = DW'(w_sxy);
    assign w_trace = KW'(w_sxx) + KW'(w_syy);

    // trace^2 is non-negative, so the arithmetic shift is a floor division.
    assign w_det = r_sxx_syy - r_sxy2;
    assign w_ktt = (KNUM_W * r_tr2) >>> K_SHIFT;
    assign w_r   = FW'(w_det) - FW'(w_ktt);
    assign w_hi  = w_r[FW-1:RW-1];

    // NOTE: assign a default before any conditional so the combinational block cannot infer a latch.
    always_comb begin
        w_r_sat = w_r[RW-1:0];
        if (!((&w_hi) || !(|w_hi))) begin
            w_r_sat = w_r[FW-1] ? {1'b1, {(RW-1){1'b0}}} : {1'b0, {(RW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ACCUM;
            r_live     <= 1'b0;
            r_sxx_syy  <= '0;
            r_sxy2     <= '0;
            r_tr2      <= '0;
            r_m_r      <= '0;
            r_m_corner <= 1'b0;
            r_m_err    <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ACCUM: if (w_done) r_state <= MUL;
                MUL: begin
                    r_sxx_syy <= w_sxx_d * w_syy_d;
                    r_sxy2    <= w_sxy_d * w_sxy_d;
                    r_tr2     <= w_trace * w_trace;
                    r_state   <= SUB;
                end
                SUB: begin
                    r_m_r      <= w_r_sat;
                    r_m_corner <= (w_r_sat > bus.thresh);
                    r_m_err    <= w_err;
                    r_state    <= OUT;
                end
                OUT: if (bus.m_ready) r_state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_harris_response_pipe.sv
// Randomised and directed bench for harris_response_pipe at RW=48 and RW=16,
// scored against a wide-integer reference of the Harris response.
module tb_harris_response_pipe;
    localparam int GW = 16, WIN = 4, N = WIN * WIN, K_NUM = 5, K_SHIFT = 7;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0, errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    harris_response_pipe_if #(.GW(GW), .RW(48)) bus_a ();
    harris_response_pipe_if #(.GW(GW), .RW(16)) bus_b ();

    harris_response_pipe #(.GW(GW), .WIN(WIN), .K_NUM(K_NUM), .K_SHIFT(K_SHIFT), .RW(48))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    harris_response_pipe #(.GW(GW), .WIN(WIN), .K_NUM(K_NUM), .K_SHIFT(K_SHIFT), .RW(16))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    logic signed [GW-1:0] win_gx [N];
    logic signed [GW-1:0] win_gy [N];
    int                   last_pos;
    logic signed [47:0]   th_a;
    logic signed [15:0]   th_b;
    int                   first_acc;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic signed [127:0] model_r();
        logic signed [127:0] sxx, syy, sxy, det, tr, pow2;
        sxx = 0; syy = 0; sxy = 0;
        for (int i = 0; i < N; i++) begin
            sxx += longint'(win_gx[i]) * longint'(win_gx[i]);
            syy += longint'(win_gy[i]) * longint'(win_gy[i]);
            sxy += longint'(win_gx[i]) * longint'(win_gy[i]);
        end
        det  = sxx * syy - sxy * sxy;
        tr   = sxx + syy;
        pow2 = 1;
        pow2 = pow2 << K_SHIFT;
        return det - (K_NUM * tr * tr) / pow2;
    endfunction

    function automatic logic signed [127:0] sat(input logic signed [127:0] r, input int w);
        logic signed [127:0] hi, lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -hi - 128'sd1;
        if (r > hi) return hi;
        if (r < lo) return lo;
        return r;
    endfunction

    task automatic set_s(input logic v, input logic signed [GW-1:0] gx, input logic signed [GW-1:0] gy,
                         input logic last);
        bus_a.s_valid = v; bus_a.s_gx = gx; bus_a.s_gy = gy; bus_a.s_last = last;
        bus_b.s_valid = v; bus_b.s_gx = gx; bus_b.s_gy = gy; bus_b.s_last = last;
    endtask

    task automatic set_ready(input logic v);
        bus_a.m_ready = v;
        bus_b.m_ready = v;
    endtask

    task automatic set_th(input logic signed [47:0] a, input logic signed [15:0] b);
        th_a = a; th_b = b;
        bus_a.thresh = a; bus_b.thresh = b;
    endtask

    task automatic fill(input logic signed [GW-1:0] gx, input logic signed [GW-1:0] gy);
        for (int i = 0; i < N; i++) begin
            win_gx[i] = gx; win_gy[i] = gy;
        end
        last_pos = N - 1;
    endtask

    task automatic run_window(input string tag, input int gap_pct, input int stall, input bit early);
        logic signed [127:0] r_full, sa, sb;
        logic signed [47:0]  exp_a;
        logic signed [15:0]  exp_b;
        logic                exp_ca, exp_cb, exp_err;
        int                  lat, guard;
        r_full  = model_r();
        sa      = sat(r_full, 48);
        sb      = sat(r_full, 16);
        exp_a   = sa[47:0];
        exp_b   = sb[15:0];
        exp_ca  = exp_a > th_a;
        exp_cb  = exp_b > th_b;
        exp_err = (last_pos != N - 1);
        if (early) set_ready(1'b1);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            if (int'($urandom_range(99)) < gap_pct) begin
                set_s(1'b0, '0, '0, 1'b0);
                repeat ($urandom_range(3, 1)) @(negedge clk);
            end
            set_s(1'b1, win_gx[i], win_gy[i], i == last_pos);
            guard = 0;
            while (!bus_a.s_ready && guard < 64) begin
                @(negedge clk);
                guard++;
            end
            check({tag, " s_ready"}, {bus_a.s_ready, bus_b.s_ready}, 2'b11);
            if (!bus_a.s_ready) return;
            if (i == 0) first_acc = cyc;
            @(posedge clk);
        end
        #1 set_s(1'b0, '0, '0, 1'b0);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!bus_a.m_valid && lat < 10);
        check({tag, " latency"}, lat, 2);
        check({tag, " m_valid_b"}, bus_b.m_valid, 1'b1);
        check({tag, " m_r_a"}, bus_a.m_r, exp_a);
        check({tag, " corner_a"}, bus_a.m_corner, exp_ca);
        check({tag, " err_a"}, bus_a.m_err, exp_err);
        check({tag, " m_r_b"}, bus_b.m_r, exp_b);
        check({tag, " corner_b"}, bus_b.m_corner, exp_cb);
        check({tag, " err_b"}, bus_b.m_err, exp_err);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            check({tag, " stall valid"}, bus_a.m_valid, 1'b1);
            check({tag, " stall s_ready"}, bus_a.s_ready, 1'b0);
            check({tag, " stall m_r"}, bus_a.m_r, exp_a);
            check({tag, " stall err"}, {bus_a.m_err, bus_a.m_corner}, {exp_err, exp_ca});
        end
        set_ready(1'b1);
        @(posedge clk);
        #1;
        check({tag, " released"}, {bus_a.m_valid, bus_b.m_valid}, 2'b00);
        check({tag, " ready again"}, bus_a.s_ready, 1'b1);
        set_ready(1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int acc0;
        logic signed [127:0] rr;
        rst_n = 1'b0;
        set_s(1'b0, '0, '0, 1'b0);
        set_ready(1'b0);
        set_th('0, '0);
        #2;
        check("reset outputs", {bus_a.m_valid, bus_a.m_corner, bus_a.m_err, bus_a.s_ready, bus_b.m_valid},
              5'b0);
        check("reset m_r", bus_a.m_r, 48'sd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("s_ready after reset", bus_a.s_ready, 1'b1);

        fill(16'sd1, 16'sd0);
        run_window("gx1", 0, 0, 1'b0);
        fill(16'sd1, 16'sd1);
        run_window("gx1gy1", 0, 0, 1'b0);
        fill(16'sd1, -16'sd1);
        run_window("gx1gym1", 0, 0, 1'b0);

        for (int i = 0; i < N; i++) begin
            win_gx[i] = (i < 8) ? 16'sd2 : 16'sd0;
            win_gy[i] = (i < 8) ? 16'sd0 : 16'sd2;
        end
        last_pos = N - 1;
        set_th(48'sd500, 16'sd500);
        run_window("det864 th500", 0, 0, 1'b0);
        set_th(48'sd864, 16'sd864);
        run_window("det864 th864", 0, 0, 1'b0);

        set_th('0, '0);
        fill(-16'sd32768, 16'sd32767);
        run_window("extreme", 0, 0, 1'b0);

        fill(16'sd3, -16'sd2);
        last_pos = 9;
        run_window("early last", 40, 5, 1'b0);
        fill(16'sd3, 16'sd1);
        run_window("after err", 0, 0, 1'b0);

        // Back-to-back windows with the sink always ready.
        fill(16'sd5, 16'sd7);
        run_window("tput0", 0, 0, 1'b1);
        acc0 = first_acc;
        fill(-16'sd4, 16'sd9);
        run_window("tput1", 0, 0, 1'b1);
        check("throughput", first_acc - acc0, N + 3);

        // Reset in the middle of a window.
        fill(16'sd1, 16'sd0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            set_s(1'b1, 16'sd1, 16'sd0, 1'b0);
            @(posedge clk);
        end
        @(negedge clk);
        rst_n = 1'b0;
        set_s(1'b0, '0, '0, 1'b0);
        #1 check("mid reset", {bus_a.s_ready, bus_a.m_valid, bus_b.m_valid}, 3'b000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("s_ready post mid reset", bus_a.s_ready, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #1 check("no partial output", bus_a.m_valid, 1'b0);
        end
        run_window("after reset", 0, 0, 1'b0);

        for (int w = 0; w < 12; w++) begin
            int mode, stall;
            mode = int'($urandom_range(2));
            for (int i = 0; i < N; i++) begin
                if (mode == 0) begin
                    win_gx[i] = GW'($urandom);
                    win_gy[i] = GW'($urandom);
                end else begin
                    win_gx[i] = GW'(int'($urandom_range(100)) - 50);
                    win_gy[i] = GW'(int'($urandom_range(100)) - 50);
                end
            end
            last_pos = ($urandom_range(3) == 0) ? int'($urandom_range(N - 1)) : N - 1;
            rr = sat(model_r(), 48);
            if (mode == 2) set_th(48'(rr + 128'(int'($urandom_range(2)) - 1)), 16'(int'($urandom_range(200)) - 100));
            else           set_th(48'($urandom), 16'($urandom));
            stall = int'($urandom_range(3));
            run_window($sformatf("rand%0d", w), int'($urandom_range(30)), stall,
                       (stall == 0) && ($urandom_range(1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
